// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner arbitration for the shared 4:1 mux.
// Macro MUX4_ARB_TIMEOUT_EN compiles in the HOLD_MAX grant limit.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   req     - request per mux input I[0..3]
//   done    - owner releases the grant at this edge
//   grant   - registered one-hot grant (or zero)
//   sel     - {S1,S2} select, index of the last granted requester
//   valid   - mux output currently owned
//   timeout - one-cycle pulse after a forced release
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       owner_drop;
    logic       release_evt;

    // Scan ptr, ptr+1, ... ; the 2-bit add gives the mod-4 wrap.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign owner_drop = !req[sel_q];

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    logic       limit_hit;

    assign limit_hit   = (hold_q == LIMIT);
    assign release_evt = done || owner_drop || limit_hit;

    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            hold_d = 8'd0;
        end else begin
            if (hold_q != 8'hFF) begin
                hold_d = hold_q + 8'd1;
            end
            // Only a release caused solely by the limit counts as forced.
            timeout_d = limit_hit && !done && !owner_drop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign release_evt = done || owner_drop;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << pick;
                    sel_d   = pick;
                    valid_d = 1'b1;
                    ptr_d   = pick + 2'd1;
                end
            end
            BUSY: begin
                // sel is left alone so the mux input stays stable.
                if (release_evt) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scoreboard bench for mux4_rr_arbiter.
// Timeout steps apply when MUX4_ARB_TIMEOUT_EN is defined.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;

    int total;
    int bad;

    // {grant, sel, valid, timeout}
    logic [7:0] sb_q[$];

    mux4_rr_arbiter #(
        .HOLD_MAX(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .sel    (sel),
        .valid  (valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive inputs, queue the expected outputs, then compare after the edge.
    task automatic step(input string tag, input logic [3:0] r,
                        input logic d, input logic [3:0] eg,
                        input logic [1:0] es, input logic ev,
                        input logic et);
        logic [7:0] exp;
        req  = r;
        done = d;
        sb_q.push_back({eg, es, ev, et});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check(tag, {grant, sel, valid, timeout}, exp);
    endtask

    task automatic do_reset();
        req  = 4'b0000;
        done = 1'b0;
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset", {grant, sel, valid, timeout}, 8'b0000_00_0_0);

        // Async reset mid-grant, no clock edge involved.
        step("rst_pre", 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {grant, sel, valid, timeout}, 8'b0000_00_0_0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("rst_idle", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        end

        // Single request then done; sel holds.
        step("single_g", 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step("single_r", 4'b0100, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0);
        step("single_i", 4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0);

        // Rotation with wrap.
        do_reset();
        step("rot0", 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step("rot0r", 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        step("rot1", 4'b1111, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step("rot1r", 4'b1111, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0);
        step("rot2", 4'b1111, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step("rot2r", 4'b1111, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0);
        step("rot3", 4'b1111, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        step("rot3r", 4'b1111, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b0);
        step("rot4", 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step("rot4r", 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Owner drop, then ptr=1 skips idle bits 1 and 2.
        do_reset();
        step("drop_g", 4'b1001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step("drop_r", 4'b1000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        step("drop_n", 4'b1000, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        step("drop_r3", 4'b0000, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0);

        do_reset();
        step("hold_g", 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
`ifdef MUX4_ARB_TIMEOUT_EN
        step("to_h1", 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step("to_h2", 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step("to_rev", 4'b0011, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
        step("to_next", 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step("sim_h1", 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step("sim_h2", 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step("sim_rel", 4'b0011, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0);
        step("sim_idle", 4'b0000, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b0);
`else
        for (int i = 0; i < 22; i++) begin
            step("no_to", 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        step("no_to_r", 4'b0011, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        step("no_to_n", 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
